mulfp_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier for the CNN accelerator's MAC datapath. Successor to the combinational FP16 multiplier. Adds configurable exponent/mantissa widths, a 3-stage pipeline with valid/ready back-pressure, special-value handling (Inf/NaN), exception flags, and optional round-to-nearest-even. Sits between the weight/activation buffers and the FP adder tree.

---
 rtl/mulfp_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_mulfp_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mulfp_pipe.sv
// mulfp_pipe: 3-stage parametrised floating-point multiplier with valid/ready.
// Define MULFP_RNE_EN for round-to-nearest-even; otherwise results truncate.
module mulfp_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] c_out,
   output logic         flag_ovf,
   output logic         flag_unf,
   output logic         flag_inv
);

   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam int EMAX = 2**EXP_W - 1;
   localparam int PW   = 2*MAN_W + 2;
   localparam int LZW  = $clog2(PW + 1);
   localparam int EW1  = EXP_W + 3;
   localparam int XW   = EXP_W + LZW + 2;
   localparam int PKW  = XW + MAN_W;

   localparam logic [EXP_W-1:0] EONES = '1;
   localparam logic [W-1:0] QNAN =
      {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

   // handshake
   logic r_v1, r_v2, r_v3;
   logic w_adv1, w_adv2, w_adv3;

   assign w_adv3    = !r_v3 || out_ready;
   assign w_adv2    = !r_v2 || w_adv3;
   assign w_adv1    = !r_v1 || w_adv2;
   assign in_ready  = w_adv1 && !rst;
   assign out_valid = r_v3;

   // stage valid bits: load from upstream when the stage advances
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         if (w_adv1) r_v1 <= in_valid;
         if (w_adv2) r_v2 <= r_v1;
         if (w_adv3) r_v3 <= r_v2;
      end
   end

   // stage 1: unpack and classify
   logic [EXP_W-1:0] w_ea, w_eb, w_eaf, w_ebf;
   logic [MAN_W-1:0] w_ma, w_mb;
   logic [MAN_W:0]   w_sa, w_sb;
   logic             w_az, w_bz, w_ai, w_bi, w_an, w_bn;
   logic             w_nan, w_inf, w_zero;
   logic [EW1-1:0]   w_esum;
   logic [PW-1:0]    w_prod;

   assign w_ea  = a_in[W-2 -: EXP_W];
   assign w_eb  = b_in[W-2 -: EXP_W];
   assign w_ma  = a_in[MAN_W-1:0];
   assign w_mb  = b_in[MAN_W-1:0];
   assign w_az  = (w_ea == '0) && (w_ma == '0);
   assign w_bz  = (w_eb == '0) && (w_mb == '0);
   assign w_ai  = (w_ea == EONES) && (w_ma == '0);
   assign w_bi  = (w_eb == EONES) && (w_mb == '0);
   assign w_an  = (w_ea == EONES) && (w_ma != '0);
   assign w_bn  = (w_eb == EONES) && (w_mb != '0);
   assign w_nan = w_an || w_bn || (w_ai && w_bz) || (w_bi && w_az);
   assign w_inf = !w_nan && (w_ai || w_bi);
   assign w_zero = !w_nan && !w_inf && (w_az || w_bz);
   // subnormals use effective exponent 1 and a zero hidden bit
   assign w_sa  = {(w_ea != '0), w_ma};
   assign w_sb  = {(w_eb != '0), w_mb};
   assign w_eaf = (w_ea == '0) ? EXP_W'(1) : w_ea;
   assign w_ebf = (w_eb == '0) ? EXP_W'(1) : w_eb;
   assign w_esum = EW1'(w_eaf) + EW1'(w_ebf) - EW1'(BIAS);
   assign w_prod = PW'(w_sa) * PW'(w_sb);

   logic                  r1_sign, r1_nan, r1_inf, r1_zero;
   logic signed [EW1-1:0] r1_exp;
   logic [PW-1:0]         r1_prod;

   // stage 1 register: class, biased exponent sum, raw product
   always_ff @(posedge clk) begin
      if (w_adv1) begin
         r1_sign <= a_in[W-1] ^ b_in[W-1];
         r1_nan  <= w_nan;
         r1_inf  <= w_inf;
         r1_zero <= w_zero;
         r1_exp  <= w_esum;
         r1_prod <= w_prod;
      end
   end

   // stage 2: leading-one detect over the full product
   logic [LZW-1:0] w_lz;
   logic [PW-1:0]  w_norm;
   logic [XW-1:0]  w_exp_n;

   // highest set bit wins, giving the leading-zero count
   always_comb begin
      w_lz = LZW'(PW);
      for (int i = 0; i < PW; i++) begin
         if (r1_prod[i]) w_lz = LZW'(PW - 1 - i);
      end
   end

   // leading one lands at the top bit; exponent counts from there
   assign w_norm  = r1_prod << w_lz;
   assign w_exp_n = {{(XW-EW1){r1_exp[EW1-1]}}, r1_exp}
                    + XW'(1) - XW'(w_lz);

   logic                 r2_sign, r2_nan, r2_inf, r2_zero;
   logic signed [XW-1:0] r2_exp;
   logic [PW-1:0]        r2_sig;

   // stage 2 register: normalised significand and exponent
   always_ff @(posedge clk) begin
      if (w_adv2) begin
         r2_sign <= r1_sign;
         r2_nan  <= r1_nan;
         r2_inf  <= r1_inf;
         r2_zero <= r1_zero;
         r2_exp  <= w_exp_n;
         r2_sig  <= w_norm;
      end
   end

   // stage 3: denormalise, round, pack
   logic [XW-1:0]    w_shx, w_e0, w_eres;
   logic             w_sub, w_big;
   logic [PW-1:0]    w_den;
   logic [MAN_W-1:0] w_man;
   logic [PKW-1:0]   w_pk;
`ifdef MULFP_RNE_EN
   logic             w_lost, w_grd, w_stk, w_inc;
`endif

   // right-shift into the subnormal range, then round into the packed word
   always_comb begin
      w_sub = r2_exp[XW-1] || (r2_exp == '0);
      w_shx = XW'(1) - r2_exp;
      w_big = w_shx > XW'(PW);
      w_den = r2_sig;
      if (w_sub) begin
         if (w_big) w_den = '0;
         else       w_den = r2_sig >> w_shx[LZW-1:0];
      end
      w_e0  = w_sub ? '0 : r2_exp;
      w_man = w_den[PW-2 -: MAN_W];
`ifdef MULFP_RNE_EN
      w_lost = 1'b0;
      if (w_sub) begin
         for (int i = 0; i < PW; i++) begin
            if (w_big || (LZW'(i) < w_shx[LZW-1:0]))
               w_lost = w_lost | r2_sig[i];
         end
      end
      w_grd = w_den[PW-2-MAN_W];
      w_stk = (|w_den[PW-3-MAN_W:0]) | w_lost;
      w_inc = w_grd && (w_stk || w_man[0]);
      // carry out of the mantissa ripples into the exponent field
      w_pk  = {w_e0, w_man} + PKW'(w_inc);
`else
      w_pk  = {w_e0, w_man};
`endif
      w_eres = w_pk[PKW-1:MAN_W];
   end

   logic [W-1:0] w_c;
   logic         w_ovf, w_unf, w_inv;

   // special cases override the arithmetic result
   always_comb begin
      w_c   = '0;
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_inv = 1'b0;
      if (r2_nan) begin
         w_c   = QNAN;
         w_inv = 1'b1;
      end else if (r2_inf) begin
         w_c = {r2_sign, EONES, {MAN_W{1'b0}}};
      end else if (r2_zero) begin
         w_c = {r2_sign, {(W-1){1'b0}}};
      end else if (w_eres >= XW'(EMAX)) begin
         w_c   = {r2_sign, EONES, {MAN_W{1'b0}}};
         w_ovf = 1'b1;
      end else begin
         w_c   = {r2_sign, w_eres[EXP_W-1:0], w_pk[MAN_W-1:0]};
         w_unf = (w_eres == '0);
      end
   end

   logic [W-1:0] r_c;
   logic         r_ovf, r_unf, r_inv;

   // stage 3 register: output word and flags, held while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c   <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         r_inv <= 1'b0;
      end else if (w_adv3) begin
         r_c   <= w_c;
         r_ovf <= w_ovf;
         r_unf <= w_unf;
         r_inv <= w_inv;
      end
   end

   assign c_out    = r_c;
   assign flag_ovf = r_ovf;
   assign flag_unf = r_unf;
   assign flag_inv = r_inv;

endmodule

// File: tb/tb_mulfp_pipe.sv
// tb_mulfp_pipe: scoreboard bench for mulfp_pipe (FP16 parameters).
// Directed values plus random operands against an integer reference model.
module tb_mulfp_pipe;

   localparam int EW   = 5;
   localparam int MW   = 10;
   localparam int BIAS = 15;
   localparam int EMAX = 31;

   typedef struct packed {
      logic [15:0] c;
      logic        ovf;
      logic        unf;
      logic        inv;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      res_t        r;
   } exp_t;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [15:0] a_in, b_in;
   logic        out_valid, out_ready;
   logic [15:0] c_out;
   logic        flag_ovf, flag_unf, flag_inv;

   int   n_chk = 0;
   int   n_err = 0;
   bit   rdy_rand = 0;
   exp_t sb[$];

   mulfp_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .c_out(c_out),
      .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // exact value = p * 2^e, quantised to the grid of the result binade
   function automatic res_t model(input logic [15:0] a,
                                  input logic [15:0] b);
      res_t   r;
      int     ea, eb, xa, xb, e, lg, et, sh, ef;
      longint ma, mb, p, m, rem, half;
      logic   s;
      bit     za, zb, ia, ib, na, nb;
      r  = '0;
      s  = a[15] ^ b[15];
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      ma = longint'(a[9:0]);
      mb = longint'(b[9:0]);
      za = (ea == 0) && (ma == 0);
      zb = (eb == 0) && (mb == 0);
      ia = (ea == EMAX) && (ma == 0);
      ib = (eb == EMAX) && (mb == 0);
      na = (ea == EMAX) && (ma != 0);
      nb = (eb == EMAX) && (mb != 0);
      if (na || nb || (ia && zb) || (ib && za)) begin
         r.c = 16'h7E00;
         r.inv = 1'b1;
         return r;
      end
      if (ia || ib) begin
         r.c = {s, 15'h7C00};
         return r;
      end
      if (za || zb) begin
         r.c = {s, 15'h0000};
         return r;
      end
      xa = (ea == 0) ? 1 : ea;
      xb = (eb == 0) ? 1 : eb;
      if (ea != 0) ma = ma + (longint'(1) << MW);
      if (eb != 0) mb = mb + (longint'(1) << MW);
      p = ma * mb;
      e = xa + xb - 2*BIAS - 2*MW;
      lg = 0;
      while ((p >> (lg + 1)) != 0) lg++;
      et = lg + e;
      if (et < 1 - BIAS) et = 1 - BIAS;
      sh = et - MW - e;
      if (sh <= 0) begin
         m = p << (-sh);
         rem = 0;
         half = 1;
      end else begin
         m = p >> sh;
         rem = p - (m << sh);
         half = longint'(1) << (sh - 1);
      end
`ifdef MULFP_RNE_EN
      if (rem > half || (rem == half && m[0])) m = m + 1;
`endif
      if (m == (longint'(1) << (MW + 1))) begin
         m = m >> 1;
         et = et + 1;
      end
      ef = et + BIAS;
      if (ef >= EMAX) begin
         r.c = {s, 15'h7C00};
         r.ovf = 1'b1;
      end else if (m < (longint'(1) << MW)) begin
         r.c = {s, 5'd0, m[9:0]};
         r.unf = 1'b1;
      end else begin
         r.c = {s, ef[4:0], m[9:0]};
      end
      return r;
   endfunction

   function automatic logic [15:0] rnd_op();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 7))
         0: v[14:10] = 5'd0;
         1: v[14:10] = 5'h1F;
         2: v[14:0] = 15'h0000;
         3: v[14:0] = 15'h7C00;
         4, 5: v[14:10] = 5'($urandom_range(8, 22));
         default: ;
      endcase
      return v;
   endfunction

   // drive a pair until accepted, then record its expected result
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input res_t r);
      exp_t e;
      int   n;
      n = 0;
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e.a = a;
            e.b = b;
            e.r = r;
            sb.push_back(e);
            break;
         end
         n++;
         if (n > 1000) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // call with an empty pipeline and out_ready high
   task automatic lat_check(input logic [15:0] a, input logic [15:0] b,
                            input res_t r);
      send(a, b, r);
      @(negedge clk);
      chk("latency_c1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_c2", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_c3", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // random back-pressure when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // monitor: pops on each transfer, checks hold under stall
   logic        stall_prev = 1'b0;
   logic [18:0] held;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", {12'd0, out_valid, c_out, flag_ovf,
                               flag_unf, flag_inv},
                {12'd0, 1'b1, held});
         stall_prev = out_valid && !out_ready;
         held = {c_out, flag_ovf, flag_unf, flag_inv};
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_output: got %h expected none",
                        c_out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk($sformatf("result %h*%h {c,ovf,unf,inv}", e.a, e.b),
                   {13'd0, c_out, flag_ovf, flag_unf, flag_inv},
                   {13'd0, e.r});
            end
         end
      end
   end

`ifdef MULFP_RNE_EN
   localparam logic [15:0] R_RND  = 16'h3E03;
   localparam logic [15:0] R_TIE  = 16'h3E02;
   localparam logic [15:0] R_SUBN = 16'h0400;
   localparam logic        U_SUBN = 1'b0;
   localparam logic [15:0] R_TOP  = 16'h7C00;
   localparam logic        O_TOP  = 1'b1;
`else
   localparam logic [15:0] R_RND  = 16'h3E02;
   localparam logic [15:0] R_TIE  = 16'h3E01;
   localparam logic [15:0] R_SUBN = 16'h03FF;
   localparam logic        U_SUBN = 1'b1;
   localparam logic [15:0] R_TOP  = 16'h7BFF;
   localparam logic        O_TOP  = 1'b0;
`endif

   initial begin
      logic [15:0] ra, rb;
      rst = 1'b1;
      in_valid = 1'b0;
      a_in = '0;
      b_in = '0;
      out_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_c_out", 32'(c_out), 32'd0);
      chk("post_rst_flags", 32'({flag_ovf, flag_unf, flag_inv}), 32'd0);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // directed values
      lat_check(16'h3C00, 16'h4000, '{16'h4000, 1'b0, 1'b0, 1'b0});
      send(16'h3E01, 16'h3C01, '{R_RND, 1'b0, 1'b0, 1'b0});
      send(16'h3C01, 16'h3E00, '{R_TIE, 1'b0, 1'b0, 1'b0});
      send(16'h7BFF, 16'h7BFF, '{16'h7C00, 1'b1, 1'b0, 1'b0});
      send(16'hFC00, 16'h3C00, '{16'hFC00, 1'b0, 1'b0, 1'b0});
      send(16'h7C00, 16'h0000, '{16'h7E00, 1'b0, 1'b0, 1'b1});
      send(16'h0001, 16'h3800, '{16'h0000, 1'b0, 1'b1, 1'b0});
      send(16'h8000, 16'h3C00, '{16'h8000, 1'b0, 1'b0, 1'b0});
      send(16'hFE01, 16'h3C00, '{16'h7E00, 1'b0, 1'b0, 1'b1});
      send(16'h7C00, 16'hFC00, '{16'hFC00, 1'b0, 1'b0, 1'b0});
      send(16'h03FF, 16'h3C01, '{R_SUBN, 1'b0, U_SUBN, 1'b0});
      send(16'h7BFE, 16'h3C01, '{R_TOP, O_TOP, 1'b0, 1'b0});
      drain();

      // stall: three accepts fill the pipe, then in_ready drops
      out_ready = 1'b0;
      send(16'h3C00, 16'h3C00, '{16'h3C00, 1'b0, 1'b0, 1'b0});
      send(16'h4000, 16'h4000, '{16'h4400, 1'b0, 1'b0, 1'b0});
      send(16'h4200, 16'h4000, '{16'h4600, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      fork
         begin
            send(16'hC000, 16'h3C00, '{16'hC000, 1'b0, 1'b0, 1'b0});
            send(16'h3800, 16'h3800, '{16'h3400, 1'b0, 1'b0, 1'b0});
            send(16'h4400, 16'hC400, '{16'hCC00, 1'b0, 1'b0, 1'b0});
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with two results in flight
      out_ready = 1'b0;
      send(16'h3C00, 16'h4200, '{16'h4200, 1'b0, 1'b0, 1'b0});
      send(16'h4000, 16'h4200, '{16'h4600, 1'b0, 1'b0, 1'b0});
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("in_rst_in_ready", 32'(in_ready), 32'd0);
      chk("in_rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      chk("rst2_c_out", 32'(c_out), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      lat_check(16'h3C00, 16'h4000, '{16'h4000, 1'b0, 1'b0, 1'b0});
      drain();

      // random operands with random back-pressure
      rdy_rand = 1'b1;
      for (int k = 0; k < 400; k++) begin
         ra = rnd_op();
         rb = rnd_op();
         send(ra, rb, model(ra, rb));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
